// File: rtl/fb_arb_pkg.sv
// Shared defaults and grant encoding for the framebuffer access arbiter.
package fb_arb_pkg;

  localparam int unsigned FB_ADDR_W       = 17;
  localparam int unsigned FB_DATA_W       = 8;
  localparam int unsigned FB_FRAME_PIXELS = 76800;
  localparam int unsigned FB_FIFO_DEPTH   = 4;
  localparam int unsigned FB_LOW_WM       = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_grant_e;

endpackage

// File: rtl/pixel_prefetch_fifo.sv
// Small synchronous FIFO holding prefetched pixels; head word is kept in a
// register so the display sees a clean registered output.
module pixel_prefetch_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] head_reg, head_next;
  logic              pop_ok;
  logic              push_ok;

  always_comb begin
    pop_ok      = pop && (count_reg != '0);
    push_ok     = push && ((count_reg != CNT_W'(DEPTH)) || pop_ok);
    count_next  = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop_ok);
    wr_ptr_next = wr_ptr_reg + PTR_W'(push_ok);
    head_next   = head_reg;
    if (flush) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else if (pop_ok) begin
      // Head advances to the next stored word, or to the word arriving now
      // when the FIFO was down to its last entry.
      if (count_reg > CNT_W'(1)) begin
        head_next = mem_reg[rd_ptr_next];
      end else if (push_ok) begin
        head_next = wdata;
      end
    end else if ((count_reg == '0) && push_ok) begin
      head_next = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign head  = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/fb_access_arbiter.sv
// Shares the framebuffer RAM between raster-order scan-out prefetch and game
// writes. Optional underflow event counter: FB_ARB_UNDERFLOW_CNT_EN.
module fb_access_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = FB_ADDR_W,
  parameter int unsigned DATA_W       = FB_DATA_W,
  parameter int unsigned FRAME_PIXELS = FB_FRAME_PIXELS,
  parameter int unsigned FIFO_DEPTH   = FB_FIFO_DEPTH,
  parameter int unsigned LOW_WM       = FB_LOW_WM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frameStart,
  input  logic              pixPop,
  output logic [DATA_W-1:0] pixData,
  output logic              pixValid,
  output logic              underflow,
  input  logic              wrValid,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata
`ifdef FB_ARB_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflowCount
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(FRAME_PIXELS);

  arb_grant_e        grant;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic              inflight_reg, inflight_next;
  logic              underflow_reg, underflow_next;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    level;
  logic              underflow_evt;
  logic              wr_in_range;

  // Reads already issued still need a FIFO slot, so they count toward level.
  assign level         = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_reg);
  assign pixValid      = (fifo_count != '0);
  assign underflow_evt = pixPop && !frameStart && !pixValid;
  assign wr_in_range   = ({1'b0, wrAddr} < FRAME_END);

  always_comb begin
    grant = ARB_IDLE;
    if (reset || frameStart) begin
      grant = ARB_IDLE;
    end else if (level < (CNT_W + 1)'(LOW_WM)) begin
      grant = ARB_READ;
    end else if (wrValid) begin
      grant = ARB_WRITE;
    end else if (level < (CNT_W + 1)'(FIFO_DEPTH)) begin
      grant = ARB_READ;
    end
  end

  always_comb begin
    memAddr        = '0;
    memWe          = 1'b0;
    memWdata       = '0;
    wrReady        = 1'b0;
    rd_addr_next   = rd_addr_reg;
    inflight_next  = 1'b0;
    underflow_next = underflow_reg || underflow_evt;
    case (grant)
      ARB_READ: begin
        memAddr       = rd_addr_reg;
        inflight_next = 1'b1;
        rd_addr_next  = (rd_addr_reg == LAST_ADDR) ? '0 : rd_addr_reg + 1'b1;
      end
      ARB_WRITE: begin
        // Out-of-frame writes are consumed so the requester never stalls.
        wrReady  = 1'b1;
        memAddr  = wrAddr;
        memWdata = wrData;
        memWe    = wr_in_range;
      end
      default: ;
    endcase
    if (frameStart) begin
      rd_addr_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_reg   <= '0;
      inflight_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      rd_addr_reg   <= rd_addr_next;
      inflight_reg  <= inflight_next;
      underflow_reg <= underflow_next;
    end
  end

  assign underflow = underflow_reg;

  // Returning read data is dropped on frameStart: it belongs to the old frame.
  pixel_prefetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (frameStart),
    .push  (inflight_reg && !frameStart),
    .pop   (pixPop && !frameStart),
    .wdata (memRdata),
    .head  (pixData),
    .count (fifo_count)
  );

`ifdef FB_ARB_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_reg, ucnt_next;

  always_comb begin
    ucnt_next = ucnt_reg;
    if (underflow_evt && (ucnt_reg != 16'hFFFF)) begin
      ucnt_next = ucnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ucnt_reg <= '0;
    end else begin
      ucnt_reg <= ucnt_next;
    end
  end

  assign underflowCount = ucnt_reg;
`endif

endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Shares the single-port pixel framebuffer RAM between the display scan-out path and the game-logic write port. Prefetches pixels in raster order into a small FIFO feeding `vgaController`, and serves game writes in the RAM cycles left over. Sits between the game engine, the framebuffer RAM and the VGA controller, all in the 50 MHz `clk` domain.

## Interface
- `ADDR_W`, 17: framebuffer address width.
- `DATA_W`, 8: pixel word width (palette index).
- `FRAME_PIXELS`, 76800: pixels per frame (320x240); read address wraps here.
- `FIFO_DEPTH`, 4: prefetch FIFO entries (power of two, ≥2).
- `LOW_WM`, 2: occupancy+in-flight level below which reads beat writes.

Ports:
- `clk` in 1: 50 MHz system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `frameStart` in 1: one-cycle pulse at start of vertical blank; restarts scan-out.
- `pixPop` in 1: display consumes head pixel this cycle.
- `pixData` out DATA_W: head-of-FIFO pixel, registered.
- `pixValid` out 1: FIFO non-empty.
- `underflow` out 1: sticky; set when `pixPop` seen with FIFO empty.
- `wrValid` in 1, `wrAddr` in ADDR_W, `wrData` in DATA_W: game write request.
- `wrReady` out 1: write granted this cycle; transfer when `wrValid && wrReady`.
- `memAddr` out ADDR_W, `memWe` out 1, `memWdata` out DATA_W: RAM command.
- `memRdata` in DATA_W: RAM read data, valid one cycle after read command.

## Operation
- One RAM access per cycle max; grant decided combinationally from registered state.
- `level` = FIFO occupancy + in-flight reads (0 or 1).
- Priority each cycle: (1) `frameStart` → no access; (2) `level < LOW_WM` → READ; (3) `wrValid` → WRITE; (4) `level < FIFO_DEPTH` → READ; (5) IDLE.
- Grant states: ARB_IDLE, ARB_READ, ARB_WRITE; re-evaluated every cycle, no hold.
- READ: `memAddr = rdAddr`, `memWe = 0`; `rdAddr` increments; after `FRAME_PIXELS-1` wraps to 0.
- WRITE: `wrReady = 1`, `memAddr = wrAddr`, `memWdata = wrData`, `memWe = 1`. If `wrAddr ≥ FRAME_PIXELS`: still accepted (`wrReady = 1`), `memWe = 0`.
- `wrReady` is 0 whenever grant is not WRITE; write requester must hold `wrValid`/`wrAddr`/`wrData` stable until transfer.
- `frameStart`: FIFO flushed, in-flight read marked discard, `rdAddr = 0`, all in the same edge; `pixPop` that cycle ignored.
- Simultaneous FIFO push and pop: allowed, occupancy unchanged; push into full FIFO cannot occur (guaranteed by `level` accounting).
- `pixPop` with FIFO empty: no state change except `underflow` set; `pixData` holds last value.
- `underflow` cleared only by `reset`.
- Reset mid-operation: in-flight read dropped, all state cleared immediately.

## Timing
- Read issued edge N; `memRdata` captured edge N+1; `pixValid`/`pixData` update after edge N+1 (visible in cycle N+2).
- After reset with no writes: reads at cycles 0,1,2,3; `pixValid` high from cycle 2.
- Write: single-cycle; command on RAM in the same cycle as `wrReady`.
- Reset values: `pixData` 0, `pixValid` 0, `underflow` 0, `wrReady` 0, `memAddr` 0, `memWe` 0, `memWdata` 0, `rdAddr` 0, FIFO empty.
- Display popping every other cycle (25 MHz pixel rate) leaves ≥1 write slot per 2 cycles.

## Configuration
- `FB_ARB_UNDERFLOW_CNT_EN` defined: extra output `underflowCount` [15:0], increments on every underflow event, saturates at 0xFFFF, reset to 0.
- Not defined: port and counter absent; only sticky `underflow` flag.

## Structure
- Package `fb_arb_pkg`: default `ADDR_W`, `DATA_W`, `FRAME_PIXELS`, `FIFO_DEPTH`, `LOW_WM` constants and grant enum (ARB_IDLE, ARB_READ, ARB_WRITE).
- Sub-module `pixel_prefetch_fifo`: synchronous FIFO with flush, push, pop, count, registered head output.
- Top holds arbitration, `rdAddr` counter, in-flight/discard flag, write gating.

## Test plan
- Reset, no pops, no writes → `memAddr` 0,1,2,3 at cycles 0–3, then idle; `pixValid` = 1 at cycle 2; `pixData` = mem[0].
- `wrValid` held high, `pixPop` every 2nd cycle → writes accepted on alternate cycles, RAM contents updated, `underflow` stays 0.
- `FRAME_PIXELS` = 16, continuous pops → read address after 15 is 0; popped data sequence mem[0..15], mem[0]…
- `frameStart` in cycle a read is in flight → that data discarded, FIFO empty next cycle, next `pixData` = mem[0].
- `pixPop` while empty → `underflow` = 1 and stays 1; with `FB_ARB_UNDERFLOW_CNT_EN`, three empty pops → `underflowCount` = 3.
- Write `wrAddr` = `FRAME_PIXELS` → `wrReady` = 1, `memWe` = 0, RAM unchanged.
